// File: rtl/hazard_stall_unit.sv
// Load-use / branch-flush / memory-wait hazard controller beside the ID stage,
// with a memory-wait watchdog and saturating performance counters.
module hazard_stall_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] freeze_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t      state;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [15:0] wait_cnt;
  logic [15:0] wait_base;
  logic [16:0] wait_inc;
  logic        rs1_used, rs2_used, hazard, wait_c, ld_stall;

  assign wait_c   = mem_access & ~dmem_ready;
  assign rs1_used = (id_opcode == OP_R) || (id_opcode == OP_LD) || (id_opcode == OP_I) ||
                    (id_opcode == OP_ST) || (id_opcode == OP_BR);
  assign rs2_used = (id_opcode == OP_R) || (id_opcode == OP_ST) || (id_opcode == OP_BR);
  assign hazard   = id_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((rs1_used & (id_rs1 == ex_rd)) | (rs2_used & (id_rs2 == ex_rd)));
  assign ld_stall = ~reset & ~wait_c & ~mem_branch_taken & hazard;

  // wait_cnt is meaningless outside MEM_WAIT, so a fresh wait always starts from zero
  assign wait_base = (state == RUN) ? 16'd0 : wait_cnt;
  assign wait_inc  = {1'b0, wait_base} + 17'd1;

  always_comb begin
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush      = 1'b0;
    freeze     = 1'b0;
    if (!reset) begin
      if (wait_c) begin
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end else if (mem_branch_taken) begin
        flush = 1'b1;
        stall = 1'b1;
      end else if (hazard) begin
        stall      = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
    end
  end

  // ID/EX shadow: only the load flag and destination matter for load-use detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_is_load <= 1'b0;
      ex_rd      <= 5'd0;
    end else if (!freeze) begin
      if (stall || flush || !id_valid) begin
        ex_is_load <= 1'b0;
        ex_rd      <= 5'd0;
      end else begin
        ex_is_load <= (id_opcode == OP_LD);
        ex_rd      <= id_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:      if (wait_c)  state <= MEM_WAIT;
        MEM_WAIT: if (!wait_c) state <= RUN;
        default:  state <= RUN;
      endcase
      if (wait_c) begin
        if (wait_base != 16'hffff) wait_cnt <= wait_inc[15:0];
        if (wait_inc == 17'(TIMEOUT)) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 16'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
      flush_events  <= '0;
    end else begin
      if (ld_stall && (stall_cycles  != '1)) stall_cycles  <= stall_cycles  + 1'b1;
      if (freeze   && (freeze_cycles != '1)) freeze_cycles <= freeze_cycles + 1'b1;
      if (flush    && (flush_events  != '1)) flush_events  <= flush_events  + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed + randomized bench for hazard_stall_unit against a rule-level reference model.
module tb_hazard_stall_unit;
  localparam int TMO   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b0;
  logic id_valid = 1'b0, mem_branch_taken = 1'b0, mem_access = 1'b0, dmem_ready = 1'b1;
  logic [6:0] id_opcode = 7'd0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic stall, pc_write, ifid_write, flush, freeze, mem_timeout;
  logic [CW-1:0] stall_cycles, freeze_cycles, flush_events;

  hazard_stall_unit #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .flush(flush),
    .freeze(freeze), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  bit m_ld; int m_rd; int m_run; bit m_tmo; int m_stc, m_frc, m_flc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit uses_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  task automatic check_regs();
    chk("stall_cycles",  32'(stall_cycles),  32'(m_stc));
    chk("freeze_cycles", 32'(freeze_cycles), 32'(m_frc));
    chk("flush_events",  32'(flush_events),  32'(m_flc));
    chk("mem_timeout",   32'(mem_timeout),   32'(m_tmo));
  endtask

  // One cycle: apply inputs, check zero-latency outputs, clock, advance model, check registers.
  task automatic step(input bit v, input logic [6:0] op, input int r1, input int r2, input int rd,
                      input bit br, input bit acc, input bit rdy);
    bit w, hz; bit e_st, e_pw, e_fl, e_fz;
    id_valid = v; id_opcode = op; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
    mem_branch_taken = br; mem_access = acc; dmem_ready = rdy;
    #1;
    w  = acc && !rdy;
    hz = v && m_ld && m_rd != 0 &&
         ((uses_rs1(op) && r1 == m_rd) || (uses_rs2(op) && r2 == m_rd));
    e_fz = w;
    e_fl = !w && br;
    e_st = !w && (br || hz);
    e_pw = !w && (br || !hz);
    chk("stall", 32'(stall), 32'(e_st));
    chk("pc_write", 32'(pc_write), 32'(e_pw));
    chk("ifid_write", 32'(ifid_write), 32'(e_pw));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("freeze", 32'(freeze), 32'(e_fz));
    @(posedge clk);
    if (!w) begin
      if (e_st || !v) begin m_ld = 0; m_rd = 0; end
      else begin m_ld = (op == 7'b0000011); m_rd = rd; end
    end
    if (w) begin m_run++; if (m_run == TMO) m_tmo = 1; end else m_run = 0;
    if (e_st && !e_fl) m_stc = (m_stc < CMAX) ? m_stc + 1 : CMAX;
    if (e_fz) m_frc = (m_frc < CMAX) ? m_frc + 1 : CMAX;
    if (e_fl) m_flc = (m_flc < CMAX) ? m_flc + 1 : CMAX;
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_pc_write", 32'(pc_write), 1);
    chk("rst_ifid_write", 32'(ifid_write), 1);
    m_ld = 0; m_rd = 0; m_run = 0; m_tmo = 0; m_stc = 0; m_frc = 0; m_flc = 0;
    check_regs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [6:0] LD = 7'b0000011, ADD = 7'b0110011, ADDI = 7'b0010011;

  initial begin
    logic [6:0] ops [7];
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
    #2;
    do_reset();

    // load x5 then add x6,x5,x1: one stall cycle, then run
    step(1, LD, 2, 0, 5, 0, 0, 1);
    step(1, ADD, 5, 1, 6, 0, 0, 1);
    chk("ldu_stall_cnt", 32'(stall_cycles), 1);
    step(1, ADD, 5, 1, 6, 0, 0, 1);
    chk("ldu_after_cnt", 32'(stall_cycles), 1);

    // load x5 then addi x7,x0,3 with rs2 field = 5: rs2 unused, no stall
    step(1, LD, 2, 0, 5, 0, 0, 1);
    step(1, ADDI, 0, 5, 7, 0, 0, 1);
    chk("addi_no_stall_cnt", 32'(stall_cycles), 1);

    // rd = 0 load never hazards
    step(1, LD, 2, 0, 0, 0, 0, 1);
    step(1, ADD, 0, 0, 6, 0, 0, 1);

    // 3 freeze cycles then ready
    for (int i = 0; i < 3; i++) step(1, ADD, 1, 2, 3, 0, 1, 0);
    step(1, ADD, 1, 2, 3, 0, 1, 1);
    chk("freeze3_cnt", 32'(freeze_cycles), 3);
    chk("freeze3_tmo", 32'(mem_timeout), 0);

    // watchdog: 4 waits raise mem_timeout, sticky past ready
    for (int i = 0; i < 4; i++) step(1, ADD, 1, 2, 3, 0, 1, 0);
    chk("tmo_set", 32'(mem_timeout), 1);
    step(1, ADD, 1, 2, 3, 0, 1, 1);
    step(1, ADD, 1, 2, 3, 0, 0, 1);
    chk("tmo_sticky", 32'(mem_timeout), 1);

    // reset asserted mid-freeze
    mem_access = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("pre_rst_freeze", 32'(freeze), 1);
    do_reset();
    chk("tmo_cleared", 32'(mem_timeout), 0);

    // branch coinciding with a load-use hazard: flush wins, no following stall
    step(1, LD, 2, 0, 5, 0, 0, 1);
    step(1, ADD, 5, 1, 6, 1, 0, 1);
    chk("br_flush_cnt", 32'(flush_events), 1);
    step(1, ADD, 5, 1, 6, 0, 0, 1);
    chk("br_no_stall_cnt", 32'(stall_cycles), 0);

    // branch during a wait: freeze first, flush once ready
    step(1, ADD, 1, 2, 3, 1, 1, 0);
    step(1, ADD, 1, 2, 3, 1, 1, 1);

    // saturate stall_cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, LD, 2, 0, 5, 0, 0, 1);
      step(1, ADD, 5, 1, 6, 0, 0, 1);
    end
    chk("stall_sat", 32'(stall_cycles), 32'(CMAX));

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      step(($urandom_range(0, 9) != 0), ops[$urandom_range(0, 6)],
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
